sigmoid_tanh_pipe: RTL and testbench
====================================

SIGMOID_TANH_PIPE -- requirements
Module: sigmoid_tanh_pipe

Interface
REQ-001 Parameter DATA_W, 16, total fixed-point word width; SHALL be ≥ FRAC_W+2.
REQ-002 Parameter FRAC_W, 8, fractional bits of every data port; SHALL be ≥ 3.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_data/in_mode present a sample.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  DATA_W  signed two's-complement x, FRAC_W fractional bits.
REQ-008 in_mode  input  1  0 = sigmoid, 1 = tanh; captured per sample.
REQ-009 out_valid  output  1  out_data/out_sat valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  DATA_W  result, FRAC_W fractional bits; unsigned for sigmoid, signed for tanh.
REQ-012 out_sat  output  1  result is fully saturated (see REQ-020).

Function
REQ-013 The datapath SHALL be a 3-stage pipeline: S1 sign/magnitude, S2 segment evaluation, S3 output mapping/register.
REQ-014 The pipeline SHALL advance when adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-015 A sample SHALL be transferred on in_valid && in_ready; its result SHALL appear on out_valid exactly 3 cycles later if adv stays high.
REQ-016 When adv is low, all stage registers, valids, out_data and out_sat SHALL hold; no sample is lost or duplicated.
REQ-017 Bubbles (in_valid low while in_ready high) SHALL propagate as cleared stage valids; back-to-back samples SHALL sustain one result per cycle.
REQ-018 S1: mag = |x|, DATA_W-bit unsigned; x = -2^(DATA_W-1) SHALL saturate to 2^(DATA_W-1)-1; neg = x[DATA_W-1]. Tanh mode: mag = min(mag<<1, 2^(DATA_W-1)-1).
REQ-019 S2: n = mag[DATA_W-1:FRAC_W], f = mag[FRAC_W-1:0], HALF = 2^(FRAC_W-1); s = (HALF - (f>>2)) >> n, with s = 0 when n ≥ FRAC_W.
REQ-020 out_sat SHALL be 1 when s = 0, else 0.
REQ-021 S3 sigmoid: out_data = neg ? s : ONE - s, ONE = 2^FRAC_W, zero-extended to DATA_W.
REQ-022 S3 tanh: t = ONE - 2*s; out_data = neg ? -t : t (two's complement, DATA_W bits).
REQ-023 All intermediate arithmetic SHALL be wide enough that no step wraps; results SHALL stay within [0, ONE] (sigmoid) or [-ONE, ONE] (tanh).
REQ-024 x = 0 SHALL yield HALF (sigmoid) and 0 (tanh); mode changes between samples SHALL need no idle cycle.

Reset
REQ-025 While rst_n is low at a clock edge, all stage valids, out_valid, out_data and out_sat SHALL clear to 0 regardless of other inputs.
REQ-026 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-027 Reset asserted mid-stream SHALL discard all in-flight samples; the first sample accepted after release SHALL emerge 3 cycles later with no residue.

Verification (DATA_W=16, FRAC_W=8, out_ready=1 unless stated)
REQ-028 Sigmoid points: x=0x0000->0x0080; 0x0100->0x00C0; 0xFF00->0x0040; 0x0180->0x00D0; each 3 cycles after acceptance, out_sat=0.
REQ-029 Saturation: sigmoid 0x7FFF->0x0100, out_sat=1; sigmoid 0x8000->0x0000, out_sat=1; tanh 0x0800->0x0100, out_sat=1.
REQ-030 Tanh points: 0x0000->0x0000; 0x0080->0x0080; 0xFF80->0xFF80; alternate modes on consecutive cycles -> correct per-sample results, one per cycle.
REQ-031 Backpressure: stream 6 samples, hold out_ready=0 once out_valid rises -> in_ready=0 the same cycle, out_data stable, later release -> all 6 results in order, none dropped or repeated.
REQ-032 Reset mid-stream: rst_n=0 for one cycle with 3 samples in flight -> out_valid=0 next cycle; next accepted x=0x0100 sigmoid -> 0x00C0 after 3 cycles only.

Source files
------------

// File: rtl/sigmoid_tanh_pipe_if.sv
// Handshake bus for the sigmoid/tanh pipeline: sample in, result out.
interface sigmoid_tanh_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;

  // Driver side (feeds samples, consumes results)
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Pipeline side
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sigmoid_tanh_pipe.sv
// Three-stage piecewise-linear sigmoid / tanh approximation with
// valid/ready flow control. S1 sign/magnitude, S2 segment value, S3 mapping.
module sigmoid_tanh_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  sigmoid_tanh_pipe_if.slave bus
);

  localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [FRAC_W:0]   HALF    = (FRAC_W+1)'(1) << (FRAC_W-1);
  localparam logic [FRAC_W+1:0] ONE     = (FRAC_W+2)'(1) << FRAC_W;

  // Pipeline advances whenever the output slot is free or being drained.
  logic w_adv;
  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Stage registers
  logic              r_s1_valid, r_s1_mode, r_s1_neg;
  logic [DATA_W-1:0] r_s1_mag;
  logic              r_s2_valid, r_s2_mode, r_s2_neg;
  logic [FRAC_W:0]   r_s2_s;
  logic              r_out_valid, r_out_sat;
  logic [DATA_W-1:0] r_out_data;

  // S1: magnitude with saturation of the most negative code; tanh doubles x.
  logic              w_neg;
  logic [DATA_W-1:0] w_abs_raw, w_abs, w_mag;
  logic [DATA_W:0]   w_dbl;
  always_comb begin
    w_neg     = bus.in_data[DATA_W-1];
    w_abs_raw = w_neg ? (DATA_W'(0) - bus.in_data) : bus.in_data;
    w_abs     = w_abs_raw[DATA_W-1] ? MAG_MAX : w_abs_raw;
    w_dbl     = {w_abs, 1'b0};
    w_mag     = w_abs;
    if (bus.in_mode) begin
      w_mag = (w_dbl > {1'b0, MAG_MAX}) ? MAG_MAX : w_dbl[DATA_W-1:0];
    end
  end

  // S2: s = (HALF - f/4) >> n, zero once the integer part reaches FRAC_W.
  logic [DATA_W-FRAC_W-1:0] w_n;
  logic [FRAC_W-1:0]        w_f;
  logic [FRAC_W:0]          w_base, w_s;
  always_comb begin
    w_n    = r_s1_mag[DATA_W-1:FRAC_W];
    w_f    = r_s1_mag[FRAC_W-1:0];
    w_base = HALF - (FRAC_W+1)'(w_f >> 2);
    w_s    = '0;
    if (32'(w_n) < FRAC_W) begin
      w_s = w_base >> w_n;
    end
  end

  // S3: map s to sigmoid (ONE - s mirrored) or tanh (ONE - 2s, signed).
  logic [FRAC_W+1:0]  w_s_ext, w_sig, w_t, w_tanh;
  logic [DATA_W-1:0]  w_res;
  always_comb begin
    w_s_ext = {1'b0, r_s2_s};
    w_sig   = r_s2_neg ? w_s_ext : (ONE - w_s_ext);
    w_t     = ONE - (w_s_ext << 1);
    w_tanh  = r_s2_neg ? ((FRAC_W+2)'(0) - w_t) : w_t;
    w_res   = r_s2_mode ? DATA_W'($signed(w_tanh)) : DATA_W'(w_sig);
  end

  // Stage register update with synchronous flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= 1'b0;
      r_s1_neg    <= 1'b0;
      r_s1_mag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_mode   <= 1'b0;
      r_s2_neg    <= 1'b0;
      r_s2_s      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_mode   <= bus.in_mode;
      r_s1_neg    <= w_neg;
      r_s1_mag    <= w_mag;
      r_s2_valid  <= r_s1_valid;
      r_s2_mode   <= r_s1_mode;
      r_s2_neg    <= r_s1_neg;
      r_s2_s      <= w_s;
      r_out_valid <= r_s2_valid;
      r_out_data  <= w_res;
      r_out_sat   <= (r_s2_s == '0);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_sigmoid_tanh_pipe.sv
// Directed bench for sigmoid_tanh_pipe: single points, saturation,
// alternating-mode streaming, backpressure and mid-stream reset.
module tb_sigmoid_tanh_pipe;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  sigmoid_tanh_pipe_if #(.DATA_W(16), .FRAC_W(8)) bus ();

  sigmoid_tanh_pipe #(.DATA_W(16), .FRAC_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream vectors: input, mode, expected data, expected saturation
  logic [15:0] vx [8];
  logic        vm [8];
  logic [15:0] ve [8];
  logic        vs [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: exact 3-cycle latency and value.
  task automatic run_single(input logic mode, input logic [15:0] x,
                            input logic [15:0] exp, input logic sat);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_mode  = mode;
    #1;
    check("acc_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    check("lat_early", 32'(bus.out_valid), 32'd0);
    step();
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    check("data", 32'(bus.out_data), 32'(exp));
    check("sat", 32'(bus.out_sat), 32'(sat));
    step();
  endtask

  // Stream n vectors; optionally stall out_ready for 'stall' cycles once out_valid rises.
  task automatic run_stream(input int n, input int stall);
    int          idx = 0;
    int          k = 0;
    int          cyc = 0;
    int          stall_left = stall;
    logic        held_ok = 1'b0;
    logic [15:0] held = '0;
    while (k < n && cyc < 100) begin
      bus.out_ready = !(bus.out_valid && stall_left > 0);
      bus.in_valid  = (idx < n);
      bus.in_data   = (idx < n) ? vx[idx] : 16'h0;
      bus.in_mode   = (idx < n) ? vm[idx] : 1'b0;
      #1;
      if (!bus.out_ready) begin
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        if (held_ok) check("bp_hold", 32'(bus.out_data), 32'(held));
        held       = bus.out_data;
        held_ok    = 1'b1;
        stall_left = stall_left - 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        check("stream_data", 32'(bus.out_data), 32'(ve[k]));
        check("stream_sat", 32'(bus.out_sat), 32'(vs[k]));
        k++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      step();
      cyc++;
    end
    check("stream_done", 32'(k), 32'(n));
    if (stall == 0) check("throughput", 32'(cyc), 32'(n + 3));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("stream_drained", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic set_vec(input int i, input logic m, input logic [15:0] x,
                         input logic [15:0] e, input logic s);
    vm[i] = m; vx[i] = x; ve[i] = e; vs[i] = s;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_sat", 32'(bus.out_sat), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Sigmoid points
    run_single(1'b0, 16'h0000, 16'h0080, 1'b0);
    run_single(1'b0, 16'h0100, 16'h00C0, 1'b0);
    run_single(1'b0, 16'hFF00, 16'h0040, 1'b0);
    run_single(1'b0, 16'h0180, 16'h00D0, 1'b0);
    // Saturation
    run_single(1'b0, 16'h7FFF, 16'h0100, 1'b1);
    run_single(1'b0, 16'h8000, 16'h0000, 1'b1);
    run_single(1'b1, 16'h0800, 16'h0100, 1'b1);
    // Tanh points
    run_single(1'b1, 16'h0000, 16'h0000, 1'b0);
    run_single(1'b1, 16'h0080, 16'h0080, 1'b0);
    run_single(1'b1, 16'hFF80, 16'hFF80, 1'b0);

    // Alternating modes, back-to-back
    set_vec(0, 1'b0, 16'h0100, 16'h00C0, 1'b0);
    set_vec(1, 1'b1, 16'h0080, 16'h0080, 1'b0);
    set_vec(2, 1'b0, 16'hFF00, 16'h0040, 1'b0);
    set_vec(3, 1'b1, 16'hFF80, 16'hFF80, 1'b0);
    set_vec(4, 1'b0, 16'h0000, 16'h0080, 1'b0);
    set_vec(5, 1'b1, 16'h0000, 16'h0000, 1'b0);
    set_vec(6, 1'b0, 16'h0180, 16'h00D0, 1'b0);
    set_vec(7, 1'b1, 16'h0800, 16'h0100, 1'b1);
    run_stream(8, 0);

    // Backpressure: 6 sigmoid samples, stall 4 cycles on first result
    set_vec(0, 1'b0, 16'h0000, 16'h0080, 1'b0);
    set_vec(1, 1'b0, 16'h0100, 16'h00C0, 1'b0);
    set_vec(2, 1'b0, 16'hFF00, 16'h0040, 1'b0);
    set_vec(3, 1'b0, 16'h0180, 16'h00D0, 1'b0);
    set_vec(4, 1'b0, 16'h7FFF, 16'h0100, 1'b1);
    set_vec(5, 1'b0, 16'h8000, 16'h0000, 1'b1);
    run_stream(6, 4);

    // Reset with three samples in flight; a sample is presented during reset too
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0180;
      bus.in_mode  = 1'b0;
      step();
    end
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("in_rst_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_sat", 32'(bus.out_sat), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    run_single(1'b0, 16'h0100, 16'h00C0, 1'b0);
    check("post_rst_idle", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
